// File: rtl/instruction_fetch_unit.sv
// Fetch stage between the program counter and decode: issues one ROM read per
// instruction, waits out the ROM latency and offers the word over valid/ready.
module instruction_fetch_unit #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               enable_increment,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               halt,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(ROM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               inc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_addr_q;
    logic               valid_q;
    logic               issue;

    // A new fetch starts from IDLE, or from HOLD in the same edge the current
    // word is handed over, so decode never sees a bubble longer than the ROM wait.
    assign issue = !halt && ((state_q == IDLE) || (state_q == HOLD && instr_ready));

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge state; a blocking update here would leak into later decisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            req_addr_q   <= '0;
            inc_q        <= 1'b0;
            instr_q      <= '0;
            instr_addr_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            inc_q <= issue;
            if (issue) begin
                rom_addr_q <= pc;
                req_addr_q <= pc;
                cnt_q      <= CNT_W'(ROM_LATENCY);
                state_q    <= WAIT;
            end
            case (state_q)
                IDLE: ;
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        instr_q      <= rom_data;
                        instr_addr_q <= req_addr_q;
                        valid_q      <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    // A handshake with halt set drains to IDLE; otherwise issue took over.
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (halt) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign enable_increment = inc_q;
    assign rom_addr         = rom_addr_q;
    assign instr            = instr_q;
    assign instr_addr       = instr_addr_q;
    assign instr_valid      = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: one instance per legal ROM latency, each
// with its own PC and ROM, checked every cycle against a transaction-level model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        instr_ready;

    logic [7:0]  pc          [2];
    logic        inc         [2];
    logic [7:0]  rom_addr    [2];
    logic [31:0] rom_data    [2];
    logic [31:0] instr       [2];
    logic [7:0]  iaddr       [2];
    logic        ivalid      [2];
    logic [31:0] rom_s1      [2];
    logic [31:0] rom_s2      [2];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .pc(pc[0]), .enable_increment(inc[0]),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .halt(halt),
        .instr(instr[0]), .instr_addr(iaddr[0]), .instr_valid(ivalid[0]),
        .instr_ready(instr_ready)
    );

    instruction_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .pc(pc[1]), .enable_increment(inc[1]),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .halt(halt),
        .instr(instr[1]), .instr_addr(iaddr[1]), .instr_valid(ivalid[1]),
        .instr_ready(instr_ready)
    );

    // ROM contents are A000_0000 + address; a second stage gives latency 2.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rom_s1[k] <= 32'hA000_0000 + 32'(rom_addr[k]);
            rom_s2[k] <= rom_s1[k];
        end
    end
    assign rom_data[0] = rom_s1[0];
    assign rom_data[1] = rom_s2[1];

    // Reference model: a fetch in flight is a timestamp; it is delivered
    // latency+1 edges after its issue edge.
    int          cyc;
    bit          m_busy  [2];
    bit          m_valid [2];
    bit          m_inc   [2];
    int          m_issue [2];
    logic [7:0]  m_pc    [2];
    logic [7:0]  m_addr  [2];
    logic [7:0]  m_rom   [2];
    logic [7:0]  m_iaddr [2];
    logic [31:0] m_instr [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit go;
            go = 1'b0;
            if (reset) begin
                m_busy[k]  = 1'b0;
                m_valid[k] = 1'b0;
                m_inc[k]   = 1'b0;
                m_rom[k]   = 8'h00;
                m_iaddr[k] = 8'h00;
                m_instr[k] = 32'h0;
            end else begin
                m_inc[k] = 1'b0;
                if (m_busy[k]) begin
                    if (cyc - m_issue[k] == k + 2) begin
                        m_busy[k]  = 1'b0;
                        m_valid[k] = 1'b1;
                        m_iaddr[k] = m_addr[k];
                        m_instr[k] = 32'hA000_0000 + 32'(m_addr[k]);
                    end
                end else if (m_valid[k]) begin
                    if (instr_ready) begin
                        m_valid[k] = 1'b0;
                        go = !halt;
                    end
                end else begin
                    go = !halt;
                end
                if (go) begin
                    m_busy[k]  = 1'b1;
                    m_issue[k] = cyc;
                    m_addr[k]  = m_pc[k];
                    m_rom[k]   = m_pc[k];
                    m_pc[k]    = m_pc[k] + 8'd1;
                    m_inc[k]   = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    // One clock: update the model, take the edge, advance each PC on its
    // enable_increment, then compare every output 1 time unit after the edge.
    task automatic tick();
        logic inc_seen [2];
        model_step();
        inc_seen[0] = inc[0];
        inc_seen[1] = inc[1];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (inc_seen[k] === 1'b1) pc[k] = pc[k] + 8'd1;
            check($sformatf("u%0d.enable_increment", k), 32'(inc[k]), 32'(m_inc[k]));
            check($sformatf("u%0d.instr_valid", k), 32'(ivalid[k]), 32'(m_valid[k]));
            check($sformatf("u%0d.rom_addr", k), 32'(rom_addr[k]), 32'(m_rom[k]));
            check($sformatf("u%0d.instr_addr", k), 32'(iaddr[k]), 32'(m_iaddr[k]));
            check($sformatf("u%0d.instr", k), instr[k], m_instr[k]);
        end
    endtask

    initial begin
        bit          ok;
        int          pulses;
        logic [7:0]  saved_addr;
        logic [7:0]  exp_a   [4];
        logic [7:0]  got_a   [4];
        logic [31:0] got_d   [4];
        int          n_got;
        int          t;
        int          first_inc [2];
        int          rise      [2][3];
        int          n_rise    [2];
        logic        prev_v    [2];

        cyc         = 0;
        reset       = 1'b1;
        halt        = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pc[k]      = 8'h00;
            m_pc[k]    = 8'h00;
            m_busy[k]  = 1'b0;
            m_valid[k] = 1'b0;
            m_inc[k]   = 1'b0;
            m_issue[k] = 0;
            m_addr[k]  = 8'h00;
        end

        // Reset for 3 cycles, then free-run towards instruction 5.
        repeat (3) tick();
        check("reset.instr_valid", 32'(ivalid[0]), 32'd0);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = m_valid[0] && (m_iaddr[0] == 8'h05);
        end
        check("reach_addr5", 32'(ok), 32'd1);

        // Stall decode for 10 cycles on instruction 5.
        instr_ready = 1'b0;
        saved_addr  = rom_addr[0];
        pulses      = 0;
        repeat (10) begin
            tick();
            if (inc[0] === 1'b1) pulses++;
        end
        check("stall.pulses", 32'(pulses), 32'd0);
        check("stall.rom_addr", 32'(rom_addr[0]), 32'(saved_addr));
        check("stall.instr", instr[0], 32'hA000_0005);
        instr_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = m_valid[0] && (m_iaddr[0] != 8'h05);
        end
        check("after_stall.instr_addr", 32'(iaddr[0]), 32'h06);

        // Raise halt while fetch 7 is waiting on the ROM.
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = m_busy[0] && (m_addr[0] == 8'h07);
        end
        check("reach_wait7", 32'(ok), 32'd1);
        halt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = m_valid[0] && (m_iaddr[0] == 8'h07);
        end
        check("halt.instr7", instr[0], 32'hA000_0007);
        pulses = 0;
        repeat (6) begin
            tick();
            if (inc[0] === 1'b1) pulses++;
        end
        check("halt.pulses", 32'(pulses), 32'd0);
        check("halt.valid_low", 32'(ivalid[0]), 32'd0);
        halt = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = m_valid[0];
        end
        check("unhalt.instr_addr", 32'(iaddr[0]), 32'h08);

        // Address wrap: drain both instances to idle, then restart at FE.
        halt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = !m_busy[0] && !m_valid[0] && !m_inc[0] && !m_busy[1] && !m_valid[1] && !m_inc[1];
        end
        check("drain_idle", 32'(ok), 32'd1);
        for (int k = 0; k < 2; k++) begin
            pc[k]   = 8'hFE;
            m_pc[k] = 8'hFE;
        end
        halt  = 1'b0;
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        n_got = 0;
        for (int i = 0; i < 40 && n_got < 4; i++) begin
            tick();
            if (ivalid[0] === 1'b1) begin
                got_a[n_got] = iaddr[0];
                got_d[n_got] = instr[0];
                n_got++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("wrap.addr%0d", j), 32'(got_a[j]), 32'(exp_a[j]));
            check($sformatf("wrap.data%0d", j), got_d[j], 32'hA000_0000 + 32'(exp_a[j]));
        end

        // Reset one cycle after an issue edge; in-flight data must be dropped.
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = m_inc[0];
        end
        check("reach_issue", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        check("midreset.valid", 32'(ivalid[0]), 32'd0);
        check("midreset.instr", instr[0], 32'h0);
        check("midreset.inc", 32'(inc[0]), 32'd0);
        reset = 1'b0;
        halt  = 1'b1;
        repeat (4) tick();
        check("midreset.no_stale", instr[0], 32'h0);
        halt = 1'b0;

        // Randomized traffic, occasional resets.
        repeat (300) begin
            halt        = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            reset       = ($urandom_range(0, 63) == 0);
            tick();
        end

        // Latency and cadence with ready held high for both latencies.
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            first_inc[k] = -1;
            n_rise[k]    = 0;
            prev_v[k]    = 1'b0;
            for (int j = 0; j < 3; j++) rise[k][j] = -1;
        end
        for (t = 0; t < 40; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (inc[k] === 1'b1 && first_inc[k] < 0) first_inc[k] = t;
                if (ivalid[k] === 1'b1 && prev_v[k] !== 1'b1 && n_rise[k] < 3) begin
                    rise[k][n_rise[k]] = t;
                    n_rise[k]++;
                end
                prev_v[k] = ivalid[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.issue_to_valid", k), 32'(rise[k][0] - first_inc[k]), 32'(k + 2));
            check($sformatf("u%0d.cadence1", k), 32'(rise[k][1] - rise[k][0]), 32'(k + 3));
            check($sformatf("u%0d.cadence2", k), 32'(rise[k][2] - rise[k][1]), 32'(k + 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
